// File: rtl/mmio_pkg.sv
// Shared constants and helpers for the MMIO responder: register offsets, CTRL bit
// positions, the hex-to-seven-segment table and the bus lane/load helpers.
package mmio_pkg;

    localparam logic [2:0] OFF_LED    = 3'd0;
    localparam logic [2:0] OFF_SEG    = 3'd1;
    localparam logic [2:0] OFF_TCOUNT = 3'd2;
    localparam logic [2:0] OFF_TCMP   = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;

    localparam int CTRL_TIMER_EN = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_PENDING  = 8;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp is always off.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct packed {
        logic pending;
        logic irq_en;
        logic timer_en;
    } ctrl_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        return (new_val & byte_mask(sel)) | (old_val & ~byte_mask(sel));
    endfunction

    // Lane-select driven alignment; irregular select patterns pass through masked.
    function automatic logic [31:0] format_load(input logic [31:0] raw,
                                                input logic [3:0]  sel,
                                                input logic        sext);
        case (sel)
            4'b0001: return {{24{sext & raw[7]}},  raw[7:0]};
            4'b0010: return {{24{sext & raw[15]}}, raw[15:8]};
            4'b0100: return {{24{sext & raw[23]}}, raw[23:16]};
            4'b1000: return {{24{sext & raw[31]}}, raw[31:24]};
            4'b0011: return {{16{sext & raw[15]}}, raw[15:0]};
            4'b1100: return {{16{sext & raw[31]}}, raw[31:16]};
            4'b1111: return raw;
            default: return raw & byte_mask(sel);
        endcase
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment driver: a prescaler paces the digit index,
// and AN/digital are registered at each digit change.
module seg_scan
    import mmio_pkg::*;
#(
    parameter int                SCAN_W   = 16,
    parameter logic [SCAN_W-1:0] SCAN_DIV = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seg,
    output logic [3:0]  AN,
    output logic [7:0]  digital
);

    localparam logic [SCAN_W-1:0] LAST = SCAN_DIV - 1'b1;

    logic [SCAN_W-1:0] presc_q;
    logic [1:0]        idx_q;
    logic              wrap;
    logic [3:0]        nibble;

    assign wrap   = (presc_q == LAST);
    assign nibble = seg[{idx_q, 2'b00} +: 4];

    // The current index is displayed on the wrap edge, so digit 0 appears SCAN_DIV
    // cycles after reset and a new SEG value is picked up without restarting the scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            AN      <= 4'b1111;
            digital <= 8'hFF;
        end else if (wrap) begin
            presc_q <= '0;
            idx_q   <= idx_q + 2'd1;
            AN      <= ~(4'b0001 << idx_q);
            digital <= SEG_TABLE[nibble];
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO target on the data-memory bus: LED, seven-segment and compare-timer registers
// in a 32-byte window, with registered, aligned and extended load responses.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0]       MMIO_BASE = 32'hFFFF_0000,
    parameter int                SCAN_W    = 16,
    parameter logic [SCAN_W-1:0] SCAN_DIV  = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  mem_sel,
    input  logic        mem_sign_ext_flag,
    output logic        hit,
    output logic [31:0] ReadData,
    output logic        resp_valid,
    output logic [3:0]  AN,
    output logic [7:0]  digital,
    output logic [7:0]  led,
    output logic        inter
);

    logic [2:0]  off;
    logic        rd_en;
    logic        wr_en;
    logic        unused_addr_bits;

    logic [15:0] seg_q;
    logic [31:0] tcount_q;
    logic [31:0] tcount_d;
    logic [31:0] tcmp_q;
    ctrl_t       ctrl_q;

    logic [31:0] raw_rd;
    logic        match;
    logic        w1c;

    assign off              = addr[4:2];
    assign hit              = (addr[31:5] == MMIO_BASE[31:5]);
    assign rd_en            = MemRd & hit;
    assign wr_en            = MemWr & hit;
    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        raw_rd = 32'h0;
        case (off)
            OFF_LED:    raw_rd = {24'h0, led};
            OFF_SEG:    raw_rd = {16'h0, seg_q};
            OFF_TCOUNT: raw_rd = tcount_q;
            OFF_TCMP:   raw_rd = tcmp_q;
            OFF_CTRL:   raw_rd = {23'h0, ctrl_q.pending, 6'h0, ctrl_q.irq_en, ctrl_q.timer_en};
            default:    raw_rd = 32'h0;
        endcase
    end

    // Bus write wins over the free-running increment; unselected bytes keep their value.
    always_comb begin
        tcount_d = tcount_q;
        if (ctrl_q.timer_en) begin
            tcount_d = tcount_q + 32'd1;
        end
        if (wr_en && (off == OFF_TCOUNT)) begin
            tcount_d = lane_merge(tcount_q, wdata, mem_sel);
        end
    end

    assign match = ctrl_q.timer_en && (tcount_q == tcmp_q);
    assign w1c   = wr_en && (off == OFF_CTRL) && mem_sel[1] && wdata[CTRL_PENDING];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led      <= 8'h0;
            seg_q    <= 16'h0;
            tcount_q <= 32'h0;
            tcmp_q   <= 32'h0;
            ctrl_q   <= '0;
            inter    <= 1'b0;
        end else begin
            tcount_q <= tcount_d;
            // A same-cycle match overrides the clear so no timer event is lost.
            ctrl_q.pending <= match | (ctrl_q.pending & ~w1c);
            inter          <= ctrl_q.pending & ctrl_q.irq_en;
            if (wr_en && (off == OFF_LED) && mem_sel[0]) begin
                led <= wdata[7:0];
            end
            if (wr_en && (off == OFF_SEG)) begin
                if (mem_sel[0]) seg_q[7:0]  <= wdata[7:0];
                if (mem_sel[1]) seg_q[15:8] <= wdata[15:8];
            end
            if (wr_en && (off == OFF_TCMP)) begin
                tcmp_q <= lane_merge(tcmp_q, wdata, mem_sel);
            end
            if (wr_en && (off == OFF_CTRL) && mem_sel[0]) begin
                ctrl_q.timer_en <= wdata[CTRL_TIMER_EN];
                ctrl_q.irq_en   <= wdata[CTRL_IRQ_EN];
            end
        end
    end

    // resp_valid is a one-cycle pulse in the cycle after MemRd&hit, with no back-pressure;
    // ReadData carries the pre-write register value and holds until the next response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ReadData   <= 32'h0;
            resp_valid <= 1'b0;
        end else begin
            resp_valid <= rd_en;
            if (rd_en) begin
                ReadData <= format_load(raw_rd, mem_sel, mem_sign_ext_flag);
            end
        end
    end

    seg_scan #(
        .SCAN_W   (SCAN_W),
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .clk     (clk),
        .reset   (reset),
        .seg     (seg_q),
        .AN      (AN),
        .digital (digital)
    );

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder with a behavioural register/load model.
module tb_mmio_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk;
    logic        reset;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mem_sel;
    logic        mem_sign_ext_flag;
    logic        hit;
    logic [31:0] ReadData;
    logic        resp_valid;
    logic [3:0]  AN;
    logic [7:0]  digital;
    logic [7:0]  led;
    logic        inter;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_reg  [8];
    logic [31:0] m_mask [8];
    logic [7:0]  seg_ref [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    mmio_responder #(
        .MMIO_BASE (BASE),
        .SCAN_W    (16),
        .SCAN_DIV  (16'd4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .MemRd             (MemRd),
        .MemWr             (MemWr),
        .addr              (addr),
        .wdata             (wdata),
        .mem_sel           (mem_sel),
        .mem_sign_ext_flag (mem_sign_ext_flag),
        .hit               (hit),
        .ReadData          (ReadData),
        .resp_valid        (resp_valid),
        .AN                (AN),
        .digital           (digital),
        .led               (led),
        .inter             (inter)
    );

    // ---------------- clock / reset / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- drivers ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        addr = a; wdata = d; mem_sel = s; MemWr = 1'b1; MemRd = 1'b0;
        @(posedge clk); #1;
        MemWr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [3:0] s, input logic se,
                            output logic [31:0] d, output logic v);
        @(negedge clk);
        addr = a; mem_sel = s; mem_sign_ext_flag = se; MemRd = 1'b1; MemWr = 1'b0;
        @(posedge clk); #1;
        d = ReadData; v = resp_valid;
        MemRd = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [3:0] sel,
                                             input logic se);
        logic [31:0] v;
        int first;
        first = 0;
        for (int i = 3; i >= 0; i--) if (sel[i]) first = i;
        if (sel == 4'b1111) return raw;
        if ($countones(sel) == 1) begin
            v = (raw >> (8 * first)) & 32'hFF;
            if (se && v[7]) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (sel == 4'b0011 || sel == 4'b1100) begin
            v = (raw >> (8 * first)) & 32'hFFFF;
            if (se && v[15]) v = v | 32'hFFFF_0000;
            return v;
        end
        v = 32'h0;
        for (int i = 0; i < 4; i++) if (sel[i]) v = v | (32'hFF << (8 * i));
        return raw & v;
    endfunction

    task automatic ref_write(input int off, input logic [31:0] d, input logic [3:0] sel);
        for (int i = 0; i < 4; i++) if (sel[i]) m_reg[off][8*i +: 8] = d[8*i +: 8];
        m_reg[off] = m_reg[off] & m_mask[off];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h want 00000000", ReadData); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_checks++; if (AN !== 4'b1111) begin n_fail++; $display("FAIL reset_an: got %b want 1111", AN); end
        n_checks++; if (digital !== 8'hFF) begin n_fail++; $display("FAIL reset_digital: got %h want ff", digital); end
        n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h want 00", led); end
        n_checks++; if (inter !== 1'b0) begin n_fail++; $display("FAIL reset_inter: got %b want 0", inter); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_led_basic;
        logic [31:0] d;
        logic v;
        bus_write(BASE, 32'h0000_00A5, 4'b0001);
        n_checks++; if (led !== 8'hA5) begin n_fail++; $display("FAIL led_write: got %h want a5", led); end
        bus_read(BASE, 4'b1111, 1'b0, d, v);
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL led_read_valid: got %b want 1", v); end
        n_checks++; if (d !== 32'h0000_00A5) begin n_fail++; $display("FAIL led_read_data: got %h want 000000a5", d); end
        @(posedge clk); #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL led_valid_pulse: got %b want 0", resp_valid); end
        n_checks++; if (ReadData !== 32'h0000_00A5) begin n_fail++; $display("FAIL led_data_hold: got %h want 000000a5", ReadData); end
    endtask

    task automatic test_same_cycle_rw;
        bus_write(BASE, 32'h11, 4'b0001);
        @(negedge clk);
        addr = BASE; wdata = 32'h22; mem_sel = 4'b0001; mem_sign_ext_flag = 1'b0;
        MemRd = 1'b1; MemWr = 1'b1;
        @(posedge clk); #1;
        MemRd = 1'b0; MemWr = 1'b0;
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL rw_valid: got %b want 1", resp_valid); end
        n_checks++; if (ReadData !== 32'h11) begin n_fail++; $display("FAIL rw_old_data: got %h want 00000011", ReadData); end
        n_checks++; if (led !== 8'h22) begin n_fail++; $display("FAIL rw_led_new: got %h want 22", led); end
    endtask

    task automatic test_miss;
        @(negedge clk);
        addr = 32'h1000_0000; wdata = 32'hFF; mem_sel = 4'b1111; MemRd = 1'b1; MemWr = 1'b1;
        #1;
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit: got %b want 0", hit); end
        @(posedge clk); #1;
        MemRd = 1'b0; MemWr = 1'b0;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL miss_valid: got %b want 0", resp_valid); end
        n_checks++; if (led !== 8'h22) begin n_fail++; $display("FAIL miss_led: got %h want 22", led); end
    endtask

    task automatic test_load_format;
        logic [3:0]  sels [5] = '{4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0101};
        logic        ses  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_80F0, 32'h0000_00F0};
        logic [31:0] d;
        logic v;
        bus_write(BASE + 32'h4, 32'h0000_80F0, 4'b0011);
        for (int i = 0; i < 5; i++) begin
            bus_read(BASE + 32'h4, sels[i], ses[i], d, v);
            n_checks++; if (v !== 1'b1 || d !== exps[i]) begin
                n_fail++; $display("FAIL load_fmt[%0d]: got valid=%b data=%h want valid=1 data=%h", i, v, d, exps[i]);
            end
        end
    endtask

    task automatic test_random;
        bit do_rd, do_wr, in_win;
        int off;
        logic [31:0] a, d, e;
        logic [3:0] s;
        logic se;
        m_mask = '{32'hFF, 32'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
        m_reg  = '{32'h22, 32'h80F0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            do_rd  = ($urandom_range(0, 2) != 0);
            do_wr  = ($urandom_range(0, 2) == 0);
            in_win = ($urandom_range(0, 7) != 0);
            off    = $urandom_range(0, 7);
            if (off == 4) do_wr = 1'b0;
            s  = 4'($urandom_range(0, 15));
            se = 1'($urandom_range(0, 1));
            d  = $urandom();
            a  = in_win ? (BASE | (32'(off) << 2) | 32'($urandom_range(0, 3))) : ($urandom() & 32'h7FFF_FFFF);
            addr = a; wdata = d; mem_sel = s; mem_sign_ext_flag = se; MemRd = do_rd; MemWr = do_wr;
            if (do_rd && in_win) exp_q.push_back(ref_load(m_reg[off], s, se));
            if (do_wr && in_win) ref_write(off, d, s);
            @(posedge clk); #1;
            n_checks++; if (hit !== in_win) begin n_fail++; $display("FAIL rnd_hit[%0d]: addr %h got %b want %b", n, a, hit, in_win); end
            n_checks++; if (resp_valid !== (do_rd && in_win)) begin
                n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, resp_valid, (do_rd && in_win));
            end
            if (do_rd && in_win && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++; if (ReadData !== e) begin
                    n_fail++; $display("FAIL rnd_data[%0d]: off %0d sel %b se %b got %h want %h", n, off, s, se, ReadData, e);
                end
            end
            n_checks++; if (led !== m_reg[0][7:0]) begin n_fail++; $display("FAIL rnd_led[%0d]: got %h want %h", n, led, m_reg[0][7:0]); end
        end
        MemRd = 1'b0; MemWr = 1'b0;
    endtask

    task automatic test_scan;
        logic [3:0] exp_an;
        logic [7:0] exp_dig;
        int idx;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        addr = BASE + 32'h4; wdata = 32'h0000_1234; mem_sel = 4'b0011; MemWr = 1'b1; MemRd = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) MemWr = 1'b0;
            if (k < 4) begin
                exp_an = 4'b1111; exp_dig = 8'hFF;
            end else begin
                idx = ((k / 4) - 1) % 4;
                exp_an  = ~(4'b0001 << idx);
                exp_dig = seg_ref[(32'h1234 >> (4 * idx)) & 32'hF];
            end
            n_checks++; if (AN !== exp_an || digital !== exp_dig) begin
                n_fail++; $display("FAIL scan[%0d]: got AN=%b digital=%h want AN=%b digital=%h", k, AN, digital, exp_an, exp_dig);
            end
        end
    endtask

    task automatic test_timer;
        logic [31:0] d;
        logic v;
        bus_write(BASE + 32'hC, 32'd5, 4'b1111);
        bus_write(BASE + 32'h10, 32'h3, 4'b0001);
        n_checks++; if (inter !== 1'b0) begin n_fail++; $display("FAIL timer_inter[0]: got %b want 0", inter); end
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk); #1;
            n_checks++; if (inter !== (j >= 7)) begin n_fail++; $display("FAIL timer_inter[%0d]: got %b want %b", j, inter, (j >= 7)); end
        end
        bus_read(BASE + 32'h10, 4'b1111, 1'b0, d, v);
        n_checks++; if (d !== 32'h103) begin n_fail++; $display("FAIL timer_ctrl_pending: got %h want 00000103", d); end
        bus_write(BASE + 32'h10, 32'h103, 4'b0011);
        bus_read(BASE + 32'h10, 4'b1111, 1'b0, d, v);
        n_checks++; if (d !== 32'h003) begin n_fail++; $display("FAIL timer_w1c: got %h want 00000003", d); end
        n_checks++; if (inter !== 1'b0) begin n_fail++; $display("FAIL timer_inter_clear: got %b want 0", inter); end
        bus_write(BASE + 32'h8, 32'd100, 4'b1111);
        bus_read(BASE + 32'h8, 4'b1111, 1'b0, d, v);
        n_checks++; if (d !== 32'd100) begin n_fail++; $display("FAIL timer_override: got %0d want 100", d); end
        bus_write(BASE + 32'h8, 32'd5, 4'b1111);
        bus_write(BASE + 32'h10, 32'h103, 4'b0011);
        bus_read(BASE + 32'h10, 4'b1111, 1'b0, d, v);
        n_checks++; if (d !== 32'h103) begin n_fail++; $display("FAIL timer_set_wins: got %h want 00000103", d); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (inter !== 1'b1) begin n_fail++; $display("FAIL timer_inter_again: got %b want 1", inter); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic v;
        @(negedge clk);
        addr = BASE; mem_sel = 4'b1111; MemRd = 1'b1; MemWr = 1'b0;
        @(posedge clk); #1;
        MemRd = 1'b0;
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", resp_valid); end
        n_checks++; if (AN === 4'b1111) begin n_fail++; $display("FAIL mid_pre_scan: got AN=%b want a digit enabled", AN); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", resp_valid); end
        n_checks++; if (AN !== 4'b1111) begin n_fail++; $display("FAIL mid_an: got %b want 1111", AN); end
        n_checks++; if (digital !== 8'hFF) begin n_fail++; $display("FAIL mid_digital: got %h want ff", digital); end
        n_checks++; if (inter !== 1'b0) begin n_fail++; $display("FAIL mid_inter: got %b want 0", inter); end
        n_checks++; if (led !== 8'h00) begin n_fail++; $display("FAIL mid_led: got %h want 00", led); end
        @(negedge clk);
        reset = 1'b1;
        bus_read(BASE + 32'h8, 4'b1111, 1'b0, d, v);
        n_checks++; if (v !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL mid_tcount: got valid=%b data=%h want 1/00000000", v, d); end
        bus_read(BASE + 32'h10, 4'b1111, 1'b0, d, v);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_ctrl: got %h want 00000000", d); end
    endtask

    initial begin
        reset = 1'b0; MemRd = 1'b0; MemWr = 1'b0; addr = 32'h0; wdata = 32'h0;
        mem_sel = 4'h0; mem_sign_ext_flag = 1'b0;
        test_reset();
        test_led_basic();
        test_same_cycle_rw();
        test_miss();
        test_load_format();
        test_random();
        test_scan();
        test_timer();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped I/O responder on the data-memory bus: the target end of the MEM-stage load/store requests.
- Decodes MemRd/MemWr with byte selects in an I/O window and applies load alignment and sign extension to returned data.
- Owns the LED register, 4-digit seven-segment scan driver and a compare timer that raises `inter`.
- Sits beside data RAM; its ReadData is muxed into the MEM/WB load path.

Parameters:
- MMIO_BASE, 32'hFFFF_0000, base of the 32-byte I/O window (addr[31:5] match).
- SCAN_DIV, 16'd50000, clk cycles per display digit.
- SCAN_W, 16, width of the scan prescaler.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemRd  in  1  load request, single-cycle strobe.
- MemWr  in  1  store request, single-cycle strobe.
- addr  in  32  byte address.
- wdata  in  32  store data, lane-aligned.
- mem_sel  in  4  byte-lane enables.
- mem_sign_ext_flag  in  1  1 = sign-extend sub-word load.
- hit  out  1  combinational: addr inside window.
- ReadData  out  32  registered, aligned/extended load data.
- resp_valid  out  1  one-cycle pulse, ReadData valid.
- AN  out  4  digit enables, active-low.
- digital  out  8  segments {dp,g..a}, active-low.
- led  out  8  LED register.
- inter  out  1  timer interrupt, level.

Behaviour:
- Reset (reset=0, asynchronous): ReadData=0, resp_valid=0, AN=4'b1111, digital=8'hFF, led=0, inter=0, all internal registers 0, scan prescaler 0, digit index 0.
- Address map (offset = addr[4:2]):
  - 0 LED: bits[7:0].
  - 1 SEG: bits[15:0], four hex digits.
  - 2 TCOUNT.
  - 3 TCMP.
  - 4 CTRL: bit0 timer_en, bit1 irq_en, bit8 pending (read; write-1-clears).
  - 5-7: read 0, writes ignored.
- Requests with hit=0 are ignored entirely: no resp_valid, no state change.
- Write: each register byte lane i updates only when mem_sel[i]=1.
- Read:
  - Registered, latency 1. Cycle N MemRd&hit → cycle N+1 resp_valid=1 with ReadData.
  - resp_valid=0 in all other cycles; ReadData holds its last value.
  - Raw word = register value at cycle N, before any same-cycle write.
- Load formatting by mem_sel:
  - 0001/0010/0100/1000: byte from that lane to [7:0].
  - 0011/1100: halfword to [15:0].
  - 1111: word.
  - Any other pattern: raw word AND byte-mask, unshifted.
  - Sub-word results are sign-extended if mem_sign_ext_flag=1, else zero-extended.
- MemRd and MemWr together at the same address: write commits; read returns the old value.
- Timer:
  - When timer_en=1, TCOUNT increments by 1 every cycle, wrapping 32'hFFFF_FFFF→0.
  - A bus write to TCOUNT overrides that cycle's increment.
  - Match: timer_en=1 and TCOUNT==TCMP (pre-increment value) sets pending on the next edge.
  - A match and a W1C in the same cycle leave pending=1 (set wins).
  - inter = pending & irq_en, registered.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. On reaching SCAN_DIV-1 it returns to 0 and digit index advances 0→1→2→3→0.
  - AN = ~(4'b0001<<index), registered, so the first digit is driven SCAN_DIV cycles after reset.
  - digital = hex-to-7seg(SEG[4*index+3:4*index]) with dp=1 (off), active-low.
  - SEG writes take effect at the next AN/digital update edge with no scan restart.
- Reset mid-operation: a pending response is dropped, and scan and timer restart from their reset values.

Decomposition:
- Package mmio_pkg holds the offset constants (OFF_LED..OFF_CTRL), CTRL bit positions and the 16-entry hex-to-segment constant table.
- One sub-module, seg_scan (prescaler, digit index, AN/digital registers), instantiated once. Bus decode, timer and load formatting stay in the top.

Test Plan:
- Reset, then SW 32'h0000_00A5, mem_sel=0001 at FFFF_0000 → led=8'hA5. LW → resp_valid one cycle later, ReadData=32'h0000_00A5.
- SW 32'h0000_1234 to SEG with SCAN_DIV=4 → after reset AN cycles 1110,1101,1011,0111 each 4 clocks. digital shows 4 (8'h99), 3 (8'hB0), 2 (8'hA4), 1 (8'hF9).
- SEG=32'h0000_80F0, LB mem_sel=0010, sign_ext=1 → ReadData=32'h0000_0080? No: lane1 byte=8'h80 → 32'hFFFF_FF80. Same with sign_ext=0 → 32'h0000_0080. LH mem_sel=0011, sign_ext=1 → 32'hFFFF_80F0.
- TCMP=5, CTRL=3 → pending and inter=1 after the match. W1C of bit8 issued in the same cycle as a repeat match (TCOUNT rewritten to 5) → pending stays 1.
- Simultaneous MemRd+MemWr to LED (old 8'h11, new 8'h22) → ReadData=32'h11, led=8'h22. Access to 32'h1000_0000 → hit=0, no resp_valid, no change.
- Reset asserted while a read is outstanding and mid-scan → resp_valid=0, AN=4'b1111, digital=8'hFF, TCOUNT=0, inter=0 immediately, without waiting for a clock edge.
